switch_port_v2: RTL and testbench

SWITCH_PORT_V2 -- requirements
Module: switch_port_v2

---
 rtl/switch_port_v2.sv | 151 +++++++++++++++
 tb/tb_switch_port_v2.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_port_v2.sv
// Switch port: device TX handshake toward the fabric, and a fabric-fed RX FIFO presented to the device.
// Both device handshakes are 4-phase; validtx and ackrx are synchronised before use.
module switch_port_v2 #(
    parameter int  AW_DEV      = 2,
    parameter int  DW          = 8,
    parameter int  DEPTH       = 3,
    parameter int  AF_LVL      = 2,
    parameter int  SYNC_STAGES = 2,
    localparam int N_DEV       = (1 << AW_DEV) - 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [DW-1:0]     dat_i,
    input  logic [AW_DEV-1:0] adr_i,
    input  logic              validtx,
    output logic              acktx,
    output logic              req_o,
    input  logic              gnt,
    input  logic [N_DEV:0]    full_array,
    output logic [DW-1:0]     tx_dat_o,
    output logic [AW_DEV-1:0] tx_adr_o,
    output logic              tx_wen_o,
    input  logic [DW-1:0]     fifo_i,
    input  logic              wen,
    output logic              full,
    output logic              afull,
    output logic [DW-1:0]     dat_o,
    output logic              validrx,
    input  logic              ackrx,
    output logic [7:0]        ovf_cnt_o
);
    localparam logic [DEPTH:0] FIFO_N = (DEPTH+1)'(1 << DEPTH);
    localparam logic [DEPTH:0] AF_THR = (DEPTH+1)'((1 << DEPTH) - AF_LVL);

    typedef enum logic [1:0] {T_IDLE, T_REQ, T_SEND, T_ACK} tx_state_e;
    typedef enum logic [1:0] {R_IDLE, R_VALID, R_WAIT} rx_state_e;

    logic [SYNC_STAGES-1:0] vtx_sync_q, vtx_sync_d;
    logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;
    logic                   vtx_s, ack_s;

    tx_state_e         tx_state_q, tx_state_d;
    logic [DW-1:0]     tx_dat_q, tx_dat_d;
    logic [AW_DEV-1:0] tx_adr_q, tx_adr_d;

    rx_state_e        rx_state_q, rx_state_d;
    logic [DW-1:0]    mem_q [0:(1<<DEPTH)-1];
    logic [DEPTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH:0]   cnt_q, cnt_d;
    logic             full_q, full_d, afull_q, afull_d;
    logic [7:0]       ovf_q, ovf_d;
    logic [DW-1:0]    dat_q, dat_d;
    logic             wr_ok, pop;

    always_comb begin
        vtx_sync_d = {vtx_sync_q[SYNC_STAGES-2:0], validtx};
        ack_sync_d = {ack_sync_q[SYNC_STAGES-2:0], ackrx};
    end

    assign vtx_s = vtx_sync_q[SYNC_STAGES-1];
    assign ack_s = ack_sync_q[SYNC_STAGES-1];

    // The destination word is captured once on entry to T_REQ and held until the handshake closes.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_dat_d   = tx_dat_q;
        tx_adr_d   = tx_adr_q;
        case (tx_state_q)
            T_IDLE: begin
                if (vtx_s) begin
                    tx_dat_d   = dat_i;
                    tx_adr_d   = adr_i;
                    tx_state_d = T_REQ;
                end
            end
            T_REQ:   if (gnt && !full_array[tx_adr_q]) tx_state_d = T_SEND;
            T_SEND:  tx_state_d = T_ACK;
            T_ACK:   if (!vtx_s) tx_state_d = T_IDLE;
            default: tx_state_d = T_IDLE;
        endcase
    end

    // Acceptance looks only at the start-of-cycle count, so a pop never makes room for a same-cycle write.
    always_comb begin
        wr_ok    = wen && (cnt_q < FIFO_N);
        pop      = (rx_state_q == R_IDLE) && (cnt_q != '0);
        wr_ptr_d = wr_ptr_q + DEPTH'(wr_ok);
        rd_ptr_d = rd_ptr_q + DEPTH'(pop);
        cnt_d    = cnt_q + (DEPTH+1)'(wr_ok) - (DEPTH+1)'(pop);
        full_d   = (cnt_d == FIFO_N);
        afull_d  = (cnt_d >= AF_THR);
        ovf_d    = ovf_q;
        if (wen && !wr_ok && (ovf_q != 8'hFF)) ovf_d = ovf_q + 8'd1;
        dat_d    = pop ? mem_q[rd_ptr_q] : dat_q;
        rx_state_d = rx_state_q;
        case (rx_state_q)
            R_IDLE:  if (pop) rx_state_d = R_VALID;
            R_VALID: if (ack_s) rx_state_d = R_WAIT;
            R_WAIT:  if (!ack_s) rx_state_d = R_IDLE;
            default: rx_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (wr_ok) mem_q[wr_ptr_q] <= fifo_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vtx_sync_q <= '0;
            ack_sync_q <= '0;
            tx_state_q <= T_IDLE;
            tx_dat_q   <= '0;
            tx_adr_q   <= '0;
            rx_state_q <= R_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            full_q     <= 1'b0;
            afull_q    <= 1'b0;
            ovf_q      <= '0;
            dat_q      <= '0;
        end else begin
            vtx_sync_q <= vtx_sync_d;
            ack_sync_q <= ack_sync_d;
            tx_state_q <= tx_state_d;
            tx_dat_q   <= tx_dat_d;
            tx_adr_q   <= tx_adr_d;
            rx_state_q <= rx_state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            full_q     <= full_d;
            afull_q    <= afull_d;
            ovf_q      <= ovf_d;
            dat_q      <= dat_d;
        end
    end

    assign req_o     = (tx_state_q == T_REQ) || (tx_state_q == T_SEND);
    assign tx_wen_o  = (tx_state_q == T_SEND);
    assign acktx     = (tx_state_q == T_ACK);
    assign tx_dat_o  = tx_dat_q;
    assign tx_adr_o  = tx_adr_q;
    assign validrx   = (rx_state_q == R_VALID);
    assign dat_o     = dat_q;
    assign full      = full_q;
    assign afull     = afull_q;
    assign ovf_cnt_o = ovf_q;

endmodule

// File: tb/tb_switch_port_v2.sv
// Bench for switch_port_v2: directed scenarios with literal expectations plus a randomized run,
// all cross-checked every cycle against a transaction-level model of the port.
module tb_switch_port_v2;
    localparam int AW = 2, DW = 8, DEPTH = 3, AFL = 2, SYNC = 2;
    localparam int NENT = 1 << DEPTH;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic [DW-1:0] dat_i = '0;
    logic [AW-1:0] adr_i = '0;
    logic          validtx = 1'b0;
    logic          acktx, req_o, tx_wen_o;
    logic          gnt = 1'b0;
    logic [3:0]    full_array = '0;
    logic [DW-1:0] tx_dat_o;
    logic [AW-1:0] tx_adr_o;
    logic [DW-1:0] fifo_i = '0;
    logic          wen = 1'b0;
    logic          full, afull, validrx;
    logic [DW-1:0] dat_o;
    logic          ackrx = 1'b0;
    logic [7:0]    ovf_cnt_o;

    int n_chk = 0;
    int n_pass = 0;

    switch_port_v2 #(.AW_DEV(AW), .DW(DW), .DEPTH(DEPTH), .AF_LVL(AFL), .SYNC_STAGES(SYNC)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .dat_i(dat_i), .adr_i(adr_i), .validtx(validtx), .acktx(acktx),
        .req_o(req_o), .gnt(gnt), .full_array(full_array),
        .tx_dat_o(tx_dat_o), .tx_adr_o(tx_adr_o), .tx_wen_o(tx_wen_o),
        .fifo_i(fifo_i), .wen(wen), .full(full), .afull(afull),
        .dat_o(dat_o), .validrx(validrx), .ackrx(ackrx), .ovf_cnt_o(ovf_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Transaction-level model: FIFO as a queue, handshakes as open/closed flags.
    logic [DW-1:0] mq[$];
    bit            vq[$], aq[$];
    bit            rx_show, rx_rel, tx_pend, tx_wr, tx_ak;
    logic [DW-1:0] m_dat, m_txd;
    logic [AW-1:0] m_txa;
    int            m_ovf;

    task automatic model_step();
        bit vs, as, take, acc;
        int n;
        if (!rst_ni) begin
            mq.delete(); vq.delete(); aq.delete();
            rx_show = 0; rx_rel = 0; tx_pend = 0; tx_wr = 0; tx_ak = 0;
            m_dat = '0; m_txd = '0; m_txa = '0; m_ovf = 0;
            return;
        end
        vs = (vq.size() >= SYNC) ? vq[vq.size()-SYNC] : 1'b0;
        as = (aq.size() >= SYNC) ? aq[aq.size()-SYNC] : 1'b0;
        vq.push_back(validtx); if (vq.size() > SYNC) void'(vq.pop_front());
        aq.push_back(ackrx);   if (aq.size() > SYNC) void'(aq.pop_front());

        if (tx_wr) begin tx_wr = 0; tx_ak = 1; end
        else if (tx_ak) begin if (!vs) tx_ak = 0; end
        else if (tx_pend) begin
            if (gnt && !full_array[m_txa]) begin tx_pend = 0; tx_wr = 1; end
        end else if (vs) begin tx_pend = 1; m_txd = dat_i; m_txa = adr_i; end

        n    = mq.size();
        take = !rx_show && !rx_rel && (n > 0);
        acc  = wen && (n < NENT);
        if (wen && !acc && m_ovf < 255) m_ovf++;
        if (take) m_dat = mq.pop_front();
        if (acc) mq.push_back(fifo_i);
        if (rx_show && as) begin rx_show = 0; rx_rel = 1; end
        else if (rx_rel && !as) rx_rel = 0;
        if (take) rx_show = 1;
    endtask

    always begin
        @(posedge clk);
        model_step();
        #1;
        chk("cyc_tx_ctl", {req_o, tx_wen_o, acktx}, {tx_pend | tx_wr, tx_wr, tx_ak});
        chk("cyc_tx_dat", tx_dat_o, m_txd);
        chk("cyc_tx_adr", tx_adr_o, m_txa);
        chk("cyc_validrx", validrx, rx_show);
        chk("cyc_dat_o", dat_o, m_dat);
        chk("cyc_flags", {full, afull}, {mq.size() == NENT, mq.size() >= NENT - AFL});
        chk("cyc_ovf", ovf_cnt_o, m_ovf);
    end

    task automatic wait_rx(input logic val, input string nm);
        int k = 0;
        while (validrx !== val && k < 40) begin @(negedge clk); k++; end
        chk(nm, validrx, val);
    endtask

    task automatic wait_ack(input logic val, input string nm);
        int k = 0;
        while (acktx !== val && k < 40) begin @(negedge clk); k++; end
        chk(nm, acktx, val);
    endtask

    task automatic rx_take(input logic [DW-1:0] exp, input string nm);
        wait_rx(1'b1, {nm, "_vld"});
        chk({nm, "_dat"}, dat_o, exp);
        ackrx = 1'b1;
        @(negedge clk);
        wait_rx(1'b0, {nm, "_drop"});
        ackrx = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic tx_finish(input logic [DW-1:0] d, input logic [AW-1:0] a, input string nm);
        int pulses = 0;
        int k = 0;
        logic [DW-1:0] pd = '0;
        logic [AW-1:0] pa = '0;
        while (acktx !== 1'b1 && k < 40) begin
            @(negedge clk); k++;
            if (tx_wen_o === 1'b1) begin pulses++; pd = tx_dat_o; pa = tx_adr_o; end
        end
        chk({nm, "_ack"}, acktx, 1);
        chk({nm, "_pulses"}, pulses, 1);
        chk({nm, "_pdat"}, pd, d);
        chk({nm, "_padr"}, pa, a);
        repeat (4) @(negedge clk);
        chk({nm, "_ack_hold"}, {acktx, req_o, tx_wen_o}, 3'b100);
        validtx = 1'b0;
        wait_ack(1'b0, {nm, "_ack_drop"});
    endtask

    task automatic tx_run(input logic [DW-1:0] d, input logic [AW-1:0] a, input string nm);
        dat_i = d; adr_i = a; validtx = 1'b1;
        tx_finish(d, a, nm);
    endtask

    initial begin
        int pulses;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ctl", {req_o, tx_wen_o, acktx, validrx, full, afull}, 6'b0);
        chk("rst_data", {tx_dat_o, tx_adr_o, dat_o, ovf_cnt_o}, '0);
        @(negedge clk); rst_ni = 1'b1;
        repeat (2) @(negedge clk);

        // RX basic latency and handshake
        wen = 1'b1; fifo_i = 8'hA5;
        @(negedge clk); wen = 1'b0;
        chk("rx_lat_e", validrx, 0);
        @(negedge clk);
        chk("rx_lat_e1", validrx, 1);
        chk("rx_lat_dat", dat_o, 8'hA5);
        rx_take(8'hA5, "rx_basic");
        chk("rx_idle_after", validrx, 0);

        // Fill to overflow with the device not acknowledging
        for (int i = 1; i <= 10; i++) begin
            wen = 1'b1; fifo_i = DW'(i);
            @(negedge clk);
            chk("fill_full", full, i >= 9);
            chk("fill_afull", afull, i >= 7);
            chk("fill_ovf", ovf_cnt_o, (i >= 10) ? 1 : 0);
        end
        wen = 1'b0;
        chk("fill_head_vld", validrx, 1);
        chk("fill_head_dat", dat_o, 1);
        chk("model_size_full", mq.size(), 8);
        chk("model_ovf_one", m_ovf, 1);

        // Write while full in the same cycle as a pop: dropped, count 7
        ackrx = 1'b1;
        @(negedge clk);
        wait_rx(1'b0, "sim_ack");
        ackrx = 1'b0;
        repeat (3) @(negedge clk);
        wen = 1'b1; fifo_i = 8'hEE;
        @(negedge clk); wen = 1'b0;
        chk("sim_ovf", ovf_cnt_o, 2);
        chk("sim_full", full, 0);
        chk("sim_afull", afull, 1);
        chk("sim_vld", validrx, 1);
        chk("sim_dat", dat_o, 2);
        chk("model_size_sim", mq.size(), 7);
        for (int v = 2; v <= 9; v++) rx_take(DW'(v), "drain");
        chk("drain_flags", {full, afull, validrx}, 3'b000);

        // TX to a blocked destination, then unblocked
        dat_i = 8'h3C; adr_i = 2'd2; full_array = 4'b0100; gnt = 1'b1; validtx = 1'b1;
        pulses = 0;
        repeat (12) begin @(negedge clk); if (tx_wen_o === 1'b1) pulses++; end
        chk("blk_req", req_o, 1);
        chk("blk_pulses", pulses, 0);
        chk("blk_ack", acktx, 0);
        chk("blk_adr", tx_adr_o, 2);
        chk("blk_dat", tx_dat_o, 8'h3C);
        dat_i = 8'h00; full_array = 4'b0000;
        tx_finish(8'h3C, 2'd2, "blk");

        // TX latency with grant and free destination
        dat_i = 8'h5A; adr_i = 2'd1; validtx = 1'b1;
        repeat (3) @(negedge clk);
        chk("lat_n3_wen", tx_wen_o, 0);
        chk("lat_n3_req", req_o, 1);
        @(negedge clk);
        chk("lat_n4_wen", tx_wen_o, 1);
        chk("lat_n4_dat", tx_dat_o, 8'h5A);
        @(negedge clk);
        chk("lat_n5_wen", tx_wen_o, 0);
        chk("lat_n5_ack", acktx, 1);
        validtx = 1'b0;
        wait_ack(1'b0, "lat_drop");

        // Reset during T_SEND with RX presenting
        wen = 1'b1; fifo_i = 8'h77;
        @(negedge clk); fifo_i = 8'h88;
        @(negedge clk); wen = 1'b0;
        wait_rx(1'b1, "rst_setup_rx");
        dat_i = 8'h11; adr_i = 2'd0; validtx = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_setup_send", tx_wen_o, 1);
        chk("rst_setup_ovf", ovf_cnt_o, 2);
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_ctl", {req_o, tx_wen_o, acktx, validrx, full, afull}, 6'b0);
        chk("arst_tx_data", {tx_dat_o, tx_adr_o}, '0);
        chk("arst_dat_o", dat_o, 0);
        chk("arst_ovf", ovf_cnt_o, 0);
        @(negedge clk); validtx = 1'b0; rst_ni = 1'b1;
        repeat (6) @(negedge clk);
        chk("post_rst_empty", validrx, 0);
        chk("post_rst_tx_idle", {req_o, acktx}, 2'b00);
        tx_run(8'h99, 2'd3, "post_rst_tx");
        wen = 1'b1; fifo_i = 8'h42;
        @(negedge clk); wen = 1'b0;
        rx_take(8'h42, "post_rst_rx");

        // Overflow counter saturation
        rst_ni = 1'b0;
        @(negedge clk); rst_ni = 1'b1;
        for (int i = 1; i <= 309; i++) begin
            wen = 1'b1; fifo_i = DW'(i);
            @(negedge clk);
            if (i == 263) chk("sat_254", ovf_cnt_o, 254);
            if (i == 264) chk("sat_255", ovf_cnt_o, 255);
        end
        wen = 1'b0;
        chk("sat_final", ovf_cnt_o, 255);

        // Randomized traffic with well-behaved device handshakes
        rst_ni = 1'b0;
        @(negedge clk); rst_ni = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            gnt        = ($urandom_range(0, 3) != 0);
            full_array = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            wen        = ($urandom_range(0, 2) == 0);
            fifo_i     = DW'($urandom);
            if (!validtx && !acktx && $urandom_range(0, 3) == 0) begin
                dat_i = DW'($urandom); adr_i = AW'($urandom); validtx = 1'b1;
            end else if (validtx && acktx) begin
                validtx = 1'b0;
            end
            if (!ackrx && validrx && $urandom_range(0, 1) == 1) ackrx = 1'b1;
            else if (ackrx && !validrx) ackrx = 1'b0;
        end
        wen = 1'b0; validtx = 1'b0; ackrx = 1'b0;
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

endmodule
